// File: rtl/qvalue_seq_ctrl.sv
// Q-value sequencer: Q = 0.5*energy_ratio + 0.5/hops using one shared serial restoring divider.
// Define QVALUE_ENERGY_TERM_EN to include the energy term; otherwise Q = 1/hops only.
//
// state   | meaning
// IDLE    | waiting for start; results held
// DIV_HOP | 4096 / hopsFromSink, one quotient bit per clock
// DIV_EN  | ((myE-minE)<<FRAC_BITS) / (maxE-minE), saturated to 1.0
// SUM     | results visible, done pulse
module qvalue_seq_ctrl #(
  parameter int WORD_WIDTH = 16,
  parameter int FRAC_BITS  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic [WORD_WIDTH-1:0] hopsFromSink,
  input  logic [WORD_WIDTH-1:0] minEnergy,
  input  logic [WORD_WIDTH-1:0] maxEnergy,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [WORD_WIDTH-1:0] myQValue,
  output logic [WORD_WIDTH-1:0] myQValue_hop,
  output logic [WORD_WIDTH-1:0] myQValue_energy
);

  localparam int W  = WORD_WIDTH;
  localparam int D  = WORD_WIDTH + FRAC_BITS;
  localparam int CW = $clog2(D + 1);

  localparam logic [D-1:0]  ONE_FX = {{(D-1){1'b0}}, 1'b1} << FRAC_BITS;
  localparam logic [CW-1:0] CNT_D  = CW'(D);
  localparam logic [CW-1:0] CNT_1  = CW'(1);

`ifdef QVALUE_ENERGY_TERM_EN
  typedef enum logic [1:0] {IDLE, DIV_HOP, DIV_EN, SUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, DIV_HOP, SUM} state_t;
`endif

  state_t state, state_nxt;

  logic load_hop;
  logic load_en;
  logic iterate;
  logic write_out;

  logic [D-1:0]  num_sr;
  logic [W-1:0]  den_r;
  logic [W-1:0]  rem_r;
  logic [D-1:0]  quo_r;
  logic [CW-1:0] cnt;
  logic          hop_zero_r;

  logic [W:0]    rem_shift;
  logic [W:0]    rem_diff;
  logic          rem_ge;
  logic [W-1:0]  it_rem;
  logic [D-1:0]  it_quo;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_hop  = 1'b0;
    load_en   = 1'b0;
    iterate   = 1'b0;
    write_out = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_hop  = 1'b1;
          state_nxt = DIV_HOP;
        end
      end
      DIV_HOP: begin
        // The cycle after the last hop iteration hands the divider to the next phase.
        if (cnt != '0) begin
          iterate = 1'b1;
        end else begin
`ifdef QVALUE_ENERGY_TERM_EN
          load_en   = 1'b1;
          state_nxt = DIV_EN;
`else
          write_out = 1'b1;
          state_nxt = SUM;
`endif
        end
      end
`ifdef QVALUE_ENERGY_TERM_EN
      DIV_EN: begin
        iterate = 1'b1;
        if (cnt == CNT_1) begin
          write_out = 1'b1;
          state_nxt = SUM;
        end
      end
`endif
      SUM: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------- restoring divider
  always_comb begin
    rem_shift = {rem_r, num_sr[D-1]};
    rem_ge    = (rem_shift >= {1'b0, den_r});
    rem_diff  = rem_shift - {1'b0, den_r};
    it_rem    = rem_ge ? W'(rem_diff) : W'(rem_shift);
    it_quo    = {quo_r[D-2:0], rem_ge};
  end

`ifdef QVALUE_ENERGY_TERM_EN
  logic [W-1:0] en_diff_r;
  logic [W-1:0] en_den_r;
  logic         en_bad_r;
  logic [D-1:0] hop_q_r;
  logic [D-1:0] en_sat;
  logic [D-1:0] en_fin;
  logic [W-1:0] hop_half;
  logic [W-1:0] en_half;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_diff_r <= '0;
      en_den_r  <= '0;
      en_bad_r  <= 1'b0;
      hop_q_r   <= '0;
    end else if (load_hop) begin
      en_diff_r <= (myEnergy > minEnergy) ? (myEnergy - minEnergy) : '0;
      en_den_r  <= maxEnergy - minEnergy;
      en_bad_r  <= (maxEnergy <= minEnergy);
    end else if (load_en) begin
      hop_q_r   <= hop_zero_r ? '0 : quo_r;
    end
  end

  always_comb begin
    en_sat   = (it_quo > ONE_FX) ? ONE_FX : it_quo;
    en_fin   = en_bad_r ? '0 : en_sat;
    hop_half = W'(hop_q_r >> 1);
    en_half  = W'(en_fin >> 1);
  end
`else
  logic [D-1:0] hop_fin;
  logic         unused_energy_ports;

  assign hop_fin             = hop_zero_r ? '0 : quo_r;
  assign unused_energy_ports = ^{myEnergy, minEnergy, maxEnergy};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      num_sr     <= '0;
      den_r      <= '0;
      rem_r      <= '0;
      quo_r      <= '0;
      cnt        <= '0;
      hop_zero_r <= 1'b0;
    end else if (load_hop) begin
      num_sr     <= ONE_FX;
      den_r      <= hopsFromSink;
      rem_r      <= '0;
      quo_r      <= '0;
      cnt        <= CNT_D;
      hop_zero_r <= (hopsFromSink == '0);
`ifdef QVALUE_ENERGY_TERM_EN
    end else if (load_en) begin
      num_sr     <= {en_diff_r, {FRAC_BITS{1'b0}}};
      den_r      <= en_den_r;
      rem_r      <= '0;
      quo_r      <= '0;
      cnt        <= CNT_D;
`endif
    end else if (iterate) begin
      num_sr     <= num_sr << 1;
      rem_r      <= it_rem;
      quo_r      <= it_quo;
      cnt        <= cnt - CNT_1;
    end
  end

  // -------------------------------------------------------- result regs
  always_ff @(posedge clk) begin
    if (rst) begin
      myQValue        <= '0;
      myQValue_hop    <= '0;
      myQValue_energy <= '0;
      err             <= 1'b0;
    end else if (write_out) begin
`ifdef QVALUE_ENERGY_TERM_EN
      myQValue_hop    <= hop_half;
      myQValue_energy <= en_half;
      myQValue        <= hop_half + en_half;
      err             <= hop_zero_r | en_bad_r;
`else
      myQValue_hop    <= W'(hop_fin);
      myQValue_energy <= '0;
      myQValue        <= W'(hop_fin);
      err             <= hop_zero_r;
`endif
    end
  end

endmodule

// File: tb/tb_qvalue_seq_ctrl.sv
// Self-checking bench for qvalue_seq_ctrl: vector table, hand sequences for start/reset
// corner cases, and randomized operations against an arithmetic reference model.
module tb_qvalue_seq_ctrl;

  localparam int W = 16;
  localparam int F = 12;
  localparam int D = W + F;
`ifdef QVALUE_ENERGY_TERM_EN
  localparam bit EN_TERM = 1'b1;
`else
  localparam bit EN_TERM = 1'b0;
`endif
  localparam int LAT = EN_TERM ? (2 * D + 1) : (D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  myEnergy, hopsFromSink, minEnergy, maxEnergy;
  logic          busy, done, err;
  logic [W-1:0]  myQValue, myQValue_hop, myQValue_energy;

  int n_cmp = 0;
  int n_bad = 0;

  qvalue_seq_ctrl #(.WORD_WIDTH(W), .FRAC_BITS(F)) dut (
    .clk(clk), .rst(rst), .start(start),
    .myEnergy(myEnergy), .hopsFromSink(hopsFromSink),
    .minEnergy(minEnergy), .maxEnergy(maxEnergy),
    .busy(busy), .done(done), .err(err),
    .myQValue(myQValue), .myQValue_hop(myQValue_hop), .myQValue_energy(myQValue_energy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h; int me; int mn; int mx;
    int q; int hq; int eq; int e;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Reference: Q-value straight from the arithmetic definition.
  function automatic void model(input int h, me, mn, mx, output int q, hq, eq, e);
    longint hop_q, en_q;
    e = 0;
    if (h == 0) begin hop_q = 0; e = 1; end
    else hop_q = 4096 / h;
    if (EN_TERM) begin
      if (mx <= mn) begin en_q = 0; e = 1; end
      else if (me <= mn) en_q = 0;
      else begin
        en_q = (longint'(me - mn) * 4096) / longint'(mx - mn);
        if (en_q > 4096) en_q = 4096;
      end
      hq = int'(hop_q / 2);
      eq = int'(en_q / 2);
      q  = hq + eq;
    end else begin
      hq = int'(hop_q);
      eq = 0;
      q  = hq;
    end
  endfunction

  task automatic apply(input int h, me, mn, mx);
    hopsFromSink = 16'(h);
    myEnergy     = 16'(me);
    minEnergy    = 16'(mn);
    maxEnergy    = 16'(mx);
    start        = 1'b1;
  endtask

  task automatic wait_done(output int lat);
    bit found = 1'b0;
    lat = -1;
    for (int k = 1; k <= LAT + 4; k++) begin
      @(negedge clk);
      if (done && !found) begin
        lat   = k;
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_results(input string tag, input int lat, q, hq, eq, e);
    chk({tag, " latency"}, lat, LAT);
    chk({tag, " myQValue"}, myQValue, q);
    chk({tag, " hop"}, myQValue_hop, hq);
    chk({tag, " energy"}, myQValue_energy, eq);
    chk({tag, " err"}, err, e);
  endtask

  task automatic run_check(input string tag, input int h, me, mn, mx, input bit hold,
                           input int q, hq, eq, e);
    int lat;
    @(negedge clk);
    apply(h, me, mn, mx);
    @(negedge clk);
    chk({tag, " busy"}, busy, 1);
    if (!hold) start = 1'b0;
    myEnergy     = 16'($urandom);
    hopsFromSink = 16'($urandom);
    minEnergy    = 16'($urandom);
    maxEnergy    = 16'($urandom);
    wait_done(lat);
    start = 1'b0;
    check_results(tag, lat, q, hq, eq, e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q, hq, eq, e, lat;
    bit saw_done;

    rst = 1'b1; start = 1'b0;
    myEnergy = '0; hopsFromSink = '0; minEnergy = '0; maxEnergy = '0;

`ifdef QVALUE_ENERGY_TERM_EN
    vecs.push_back('{1, 1000, 0, 1000, 4096, 2048, 2048, 0});
    vecs.push_back('{3, 500, 0, 1000, 1706, 682, 1024, 0});
    vecs.push_back('{0, 300, 200, 200, 0, 0, 0, 1});
    vecs.push_back('{2, 1500, 0, 1000, 3072, 1024, 2048, 0});
    vecs.push_back('{7, 300, 100, 900, 804, 292, 512, 0});
    vecs.push_back('{2, 50, 100, 900, 1024, 1024, 0, 0});
    vecs.push_back('{5, 10, 300, 100, 409, 409, 0, 1});
    vecs.push_back('{65535, 65535, 0, 65535, 2048, 0, 2048, 0});
`else
    vecs.push_back('{4, 1000, 0, 1000, 1024, 1024, 0, 0});
    vecs.push_back('{1, 500, 0, 1000, 4096, 4096, 0, 0});
    vecs.push_back('{3, 0, 0, 0, 1365, 1365, 0, 0});
    vecs.push_back('{0, 300, 200, 200, 0, 0, 0, 1});
    vecs.push_back('{7, 1, 2, 3, 585, 585, 0, 0});
    vecs.push_back('{5, 10, 300, 100, 819, 819, 0, 0});
    vecs.push_back('{65535, 9, 9, 9, 0, 0, 0, 0});
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset myQValue", myQValue, 0);
    chk("reset hop", myQValue_hop, 0);
    chk("reset energy", myQValue_energy, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_check($sformatf("vec%0d", i), vecs[i].h, vecs[i].me, vecs[i].mn, vecs[i].mx, 1'b0,
                vecs[i].q, vecs[i].hq, vecs[i].eq, vecs[i].e);
    end

    // Start held in the SUM cycle is ignored, then accepted on the following edge.
    model(2, 1500, 0, 1000, q, hq, eq, e);
    run_check("pre_sum", 2, 1500, 0, 1000, 1'b0, q, hq, eq, e);
    apply(4, 750, 250, 1250);
    @(negedge clk);
    chk("done pulse width", done, 0);
    chk("start in SUM ignored", busy, 0);
    chk("held myQValue", myQValue, q);
    @(negedge clk);
    chk("start after done accepted", busy, 1);
    start = 1'b0;
    wait_done(lat);
    model(4, 750, 250, 1250, q, hq, eq, e);
    check_results("post_sum", lat, q, hq, eq, e);

    // Abort by reset: second start at cycle 10, reset at 20 (with start), restart at 22.
    model(0, 1000, 0, 1000, q, hq, eq, e);
    run_check("pre_rst", 0, 1000, 0, 1000, 1'b0, q, hq, eq, e);
    @(negedge clk);
    apply(1, 1000, 0, 1000);
    @(negedge clk);
    start = 1'b0;
    saw_done = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      if (c == 9) apply(5, 20, 10, 30);
      if (c == 10) start = 1'b0;
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("abort no done", saw_done, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort err", err, 0);
    chk("abort myQValue", myQValue, 0);
    chk("abort hop", myQValue_hop, 0);
    chk("abort energy", myQValue_energy, 0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle after reset", busy, 0);
    apply(3, 500, 0, 1000);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    model(3, 500, 0, 1000, q, hq, eq, e);
    check_results("restart", lat, q, hq, eq, e);

    // Randomized operations; start is sometimes held high for the whole computation.
    for (int n = 0; n < 40; n++) begin
      int h, me, mn, mx;
      h  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 400));
      mn = int'($urandom_range(0, 3000));
      me = int'($urandom_range(0, 4000));
      mx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, mn)) : int'($urandom_range(0, 5000));
      model(h, me, mn, mx, q, hq, eq, e);
      run_check($sformatf("rnd%0d", n), h, me, mn, mx, 1'($urandom_range(0, 1)), q, hq, eq, e);
    end

    repeat (5) @(negedge clk);
    chk("hold done", done, 0);
    chk("hold myQValue", myQValue, q);
    chk("hold hop", myQValue_hop, hq);
    chk("hold energy", myQValue_energy, eq);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
